complementary_filter: RTL and testbench

Tilt-angle fusion stage that sits directly downstream of the CORDIC atan2 unit. It accepts one IMU sample at a time (accelerometer pair plus gyro rate) and drives the atan2 unit's start/x/y inputs. It captures the returned accelerometer angle and blends it with the gyro-integrated prediction into a wrapped angle estimate. The output feeds the attitude/control logic.

---
 rtl/imu_pkg.sv | 19 +
 rtl/angle_wrap.sv | 25 ++
 rtl/complementary_filter.sv | 154 +++++++++++++++
 tb/tb_complementary_filter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imu_pkg.sv
// Shared angle types and constants for the IMU fusion blocks.
// Angles are signed 16-bit, 1 LSB = 1/128 degree, legal range [-23040, +23039].
package imu_pkg;

  localparam int ANGLE_180 = 23040;
  localparam int ANGLE_360 = 46080;

  typedef logic signed [15:0] angle_t;
  typedef logic signed [17:0] wide_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    CAPTURE,
    BLEND
  } cf_state_t;

endpackage

// File: rtl/angle_wrap.sv
// Folds an 18-bit signed angle sum back into [-180, +180) degrees.
// A single correction step suffices because both addends are already legal angles.
module angle_wrap
  import imu_pkg::*;
(
  input  wide_t  v_i,
  output angle_t wrapped_o
);

  localparam wide_t POS_LIM = wide_t'(ANGLE_180);
  localparam wide_t NEG_LIM = -wide_t'(ANGLE_180);
  localparam wide_t SPAN    = wide_t'(ANGLE_360);

  wide_t fixed;

  // NOTE: assigning a default first keeps every path covered so no latch is inferred.
  always_comb begin
    fixed = v_i;
    if (v_i >= POS_LIM)     fixed = v_i - SPAN;
    else if (v_i < NEG_LIM) fixed = v_i + SPAN;
  end

  assign wrapped_o = angle_t'(fixed);

endmodule

// File: rtl/complementary_filter.sv
// Tilt-angle fusion: drives the atan2 unit, then blends its angle with a gyro prediction.
// Optional build macro CF_WATCHDOG_EN adds a WAIT-state timeout with a sticky wd_err.
module complementary_filter
  import imu_pkg::*;
#(
  parameter int ALPHA_SHIFT = 5,
  parameter int GYRO_SHIFT  = 4,
  parameter int WD_LIMIT    = 31
) (
  input  logic   clk,
  input  logic   n_rst,
  input  logic   sample_valid,
  output logic   sample_ready,
  input  angle_t accel_x,
  input  angle_t accel_y,
  input  angle_t gyro_rate,
  output logic   atan_start,
  output angle_t atan_x,
  output angle_t atan_y,
  input  logic   atan_done,
  input  angle_t atan_angle,
  output angle_t angle_est,
  output logic   est_valid,
  output logic   wd_err
);

  if (WD_LIMIT < 1) begin : g_bad_wd_limit
    $error("WD_LIMIT must be at least 1");
  end

  cf_state_t state_q, state_d;
  angle_t    atan_x_q, atan_y_q, gyro_q, acc_q, pred_q, est_q;
  logic      seeded_q, gyro_only_q;
  logic      timeout;

  angle_t gyro_delta, corr, pred_w, diff_w, est_w, est_new;

  assign gyro_delta = gyro_q >>> GYRO_SHIFT;
  assign corr       = diff_w >>> ALPHA_SHIFT;

  angle_wrap u_wrap_pred (
    .v_i      (wide_t'(est_q) + wide_t'(gyro_delta)),
    .wrapped_o(pred_w)
  );

  angle_wrap u_wrap_diff (
    .v_i      (wide_t'(acc_q) - wide_t'(pred_q)),
    .wrapped_o(diff_w)
  );

  angle_wrap u_wrap_est (
    .v_i      (wide_t'(pred_q) + wide_t'(corr)),
    .wrapped_o(est_w)
  );

  // A timeout with no seed yet has nothing to predict from, so the estimate holds.
  always_comb begin
    est_new = est_w;
    if (gyro_only_q)    est_new = seeded_q ? pred_q : est_q;
    else if (!seeded_q) est_new = acc_q;
  end

  always_comb begin
    state_d      = state_q;
    sample_ready = 1'b0;
    atan_start   = 1'b0;
    est_valid    = 1'b0;
    unique case (state_q)
      IDLE: begin
        sample_ready = 1'b1;
        if (sample_valid) state_d = START;
      end
      START: begin
        atan_start = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (atan_done)    state_d = CAPTURE;
        else if (timeout) state_d = BLEND;
      end
      CAPTURE: state_d = BLEND;
      BLEND: begin
        est_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The fresh estimate is presented combinationally so it is valid alongside est_valid.
  assign angle_est = est_valid ? est_new : est_q;
  assign atan_x    = atan_x_q;
  assign atan_y    = atan_y_q;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      // NOTE: datapath registers are reset too; they are few and drive visible outputs.
      state_q     <= IDLE;
      atan_x_q    <= '0;
      atan_y_q    <= '0;
      gyro_q      <= '0;
      acc_q       <= '0;
      pred_q      <= '0;
      est_q       <= '0;
      seeded_q    <= 1'b0;
      gyro_only_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && sample_valid) begin
        atan_x_q    <= accel_x;
        atan_y_q    <= accel_y;
        gyro_q      <= gyro_rate;
        gyro_only_q <= 1'b0;
      end
      if (state_q == CAPTURE) begin
        acc_q  <= atan_angle;
        pred_q <= pred_w;
      end
      if (state_q == WAIT && !atan_done && timeout) begin
        pred_q      <= pred_w;
        gyro_only_q <= 1'b1;
      end
      if (state_q == BLEND) begin
        est_q <= est_new;
        if (!gyro_only_q) seeded_q <= 1'b1;
      end
    end
  end

`ifdef CF_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_LIMIT + 1);

  logic [WD_W-1:0] wd_cnt_q;
  logic            wd_err_q;

  assign timeout = (state_q == WAIT) && (wd_cnt_q == WD_W'(WD_LIMIT - 1));
  assign wd_err  = wd_err_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= (state_q == WAIT) ? wd_cnt_q + 1'b1 : '0;
      if (timeout && !atan_done) wd_err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign wd_err  = 1'b0;
`endif

endmodule

// File: tb/tb_complementary_filter.sv
// Self-checking bench for complementary_filter: the bench plays the atan2 unit and
// compares every update against a plain-integer model of the fusion rules.
module tb_complementary_filter;

  localparam int AS = 5;
  localparam int GS = 4;
  localparam int WD = 31;

  logic               clk;
  logic               n_rst;
  logic               sample_valid;
  logic               sample_ready;
  logic signed [15:0] accel_x, accel_y, gyro_rate;
  logic               atan_start;
  logic signed [15:0] atan_x, atan_y;
  logic               atan_done;
  logic signed [15:0] atan_angle;
  logic signed [15:0] angle_est;
  logic               est_valid;
  logic               wd_err;

  int n_checks = 0;
  int n_pass   = 0;

  int m_est    = 0;
  bit m_seeded = 1'b0;

  complementary_filter #(
    .ALPHA_SHIFT(AS),
    .GYRO_SHIFT (GS),
    .WD_LIMIT   (WD)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .accel_x     (accel_x),
    .accel_y     (accel_y),
    .gyro_rate   (gyro_rate),
    .atan_start  (atan_start),
    .atan_x      (atan_x),
    .atan_y      (atan_y),
    .atan_done   (atan_done),
    .atan_angle  (atan_angle),
    .angle_est   (angle_est),
    .est_valid   (est_valid),
    .wd_err      (wd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int wrap_ref(int v);
    if (v >= 23040) return v - 46080;
    if (v < -23040) return v + 46080;
    return v;
  endfunction

  function automatic int floor_div(int a, int d);
    if (a < 0 && (a % d) != 0) return a / d - 1;
    return a / d;
  endfunction

  function automatic int model_pred(int gyro);
    return wrap_ref(m_est + floor_div(gyro, 1 << GS));
  endfunction

  function automatic int model_step(int acc, int gyro);
    int pred, diff;
    if (!m_seeded) begin
      m_est    = acc;
      m_seeded = 1'b1;
    end else begin
      pred  = model_pred(gyro);
      diff  = wrap_ref(acc - pred);
      m_est = wrap_ref(pred + floor_div(diff, 1 << AS));
    end
    return m_est;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, int'(sample_ready), 1);
    check({tag, "_start"}, int'(atan_start), 0);
    check({tag, "_x"}, int'(atan_x), 0);
    check({tag, "_y"}, int'(atan_y), 0);
    check({tag, "_est"}, int'(angle_est), 0);
    check({tag, "_ev"}, int'(est_valid), 0);
    check({tag, "_wd"}, int'(wd_err), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    n_rst = 1'b0;
    #1;
    m_est    = 0;
    m_seeded = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  // One full transaction; the bench answers atan_start with atan_done in cycle d.
  task automatic run_sample(input int acc, input int gyro, input int d,
                            input bit hold_valid, output int got);
    logic signed [15:0] ax, ay;
    int starts, ready_hi, early_ev, exp;
    ax = 16'($urandom);
    ay = 16'($urandom);
    atan_angle = 16'($urandom);
    got = 0;
    @(posedge clk); #1;
    check("ready_idle", int'(sample_ready), 1);
    sample_valid = 1'b1;
    accel_x      = ax;
    accel_y      = ay;
    gyro_rate    = 16'(gyro);
    @(posedge clk); #1;
    if (!hold_valid) sample_valid = 1'b0;
    starts   = int'(atan_start);
    ready_hi = int'(sample_ready);
    early_ev = int'(est_valid);
    check("start_c1", int'(atan_start), 1);
    check("atan_x", int'(atan_x), int'(ax));
    check("atan_y", int'(atan_y), int'(ay));
    for (int c = 2; c <= d + 2; c++) begin
      @(posedge clk); #1;
      starts += int'(atan_start);
      if (c <= d) begin
        ready_hi += int'(sample_ready);
        early_ev += int'(est_valid);
      end
      if (c == d) begin
        check("atan_x_held", int'(atan_x), int'(ax));
        check("atan_y_held", int'(atan_y), int'(ay));
        atan_done    = 1'b1;
        sample_valid = 1'b0;
      end
      if (c == d + 1) begin
        check("ev_capture", int'(est_valid), 0);
        atan_done  = 1'b0;
        atan_angle = 16'(acc);
      end
      if (c == d + 2) begin
        atan_angle = 16'($urandom);
        check("ev_pulse", int'(est_valid), 1);
        got = int'(angle_est);
        exp = model_step(acc, gyro);
        check("angle_est", got, exp);
      end
    end
    check("start_once", starts, 1);
    check("ready_busy", ready_hi, 0);
    check("ev_early", early_ev, 0);
    @(posedge clk); #1;
    check("ready_back", int'(sample_ready), 1);
    check("ev_single", int'(est_valid), 0);
    check("est_hold", int'(angle_est), m_est);
  endtask

  initial begin
    int got, acc, gyro, d, ev_cnt;
    logic signed [15:0] g16;

    n_rst        = 1'b0;
    sample_valid = 1'b0;
    accel_x      = '0;
    accel_y      = '0;
    gyro_rate    = '0;
    atan_done    = 1'b0;
    atan_angle   = '0;
    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    n_rst = 1'b1;

    run_sample(2560, 0, 13, 1'b0, got);
    check("seed_const", got, 2560);

    do_reset();
    run_sample(0, 0, 13, 1'b0, got);
    run_sample(3200, 0, 13, 1'b0, got);
    check("blend_const", got, 100);

    do_reset();
    run_sample(23000, 0, 13, 1'b0, got);
    run_sample(23100, 1600, 13, 1'b0, got);
    check("gyro_wrap_const", got, -22980);

    do_reset();
    run_sample(23000, 0, 13, 1'b0, got);
    run_sample(-23000, 0, 13, 1'b1, got);
    check("diff_wrap_const", got, 23002);

    // Reset asserted in WAIT; a late atan_done afterwards must be ignored.
    @(posedge clk); #1;
    sample_valid = 1'b1;
    accel_x      = 16'sd1111;
    accel_y      = 16'sd2222;
    gyro_rate    = 16'sd320;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    n_rst = 1'b0;
    #1;
    check_reset_outputs("rst_wait");
    m_est    = 0;
    m_seeded = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #1;
    atan_done = 1'b1;
    @(posedge clk); #1;
    atan_done  = 1'b0;
    atan_angle = 16'sd1234;
    ev_cnt = 0;
    repeat (4) begin
      @(posedge clk); #1;
      ev_cnt += int'(est_valid);
    end
    check("late_done_ev", ev_cnt, 0);
    check("late_done_est", int'(angle_est), 0);
    check("late_done_ready", int'(sample_ready), 1);
    run_sample(5000, 777, 13, 1'b0, got);
    check("reseed_const", got, 5000);

    for (int i = 0; i < 25; i++) begin
      acc  = int'($urandom_range(46079)) - 23040;
      g16  = 16'($urandom);
      gyro = int'(g16);
      d    = int'($urandom_range(16, 2));
      if (i % 4 == 1) begin
        @(posedge clk); #1;
        atan_done = 1'b1;
        @(posedge clk); #1;
        atan_done = 1'b0;
        check("idle_done_ev", int'(est_valid), 0);
        check("idle_done_ready", int'(sample_ready), 1);
      end
      run_sample(acc, gyro, d, 1'(i % 3 == 0), got);
    end

`ifdef CF_WATCHDOG_EN
    begin
      int first_ev, exp_pred;
      exp_pred = model_pred(1600);
      @(posedge clk); #1;
      sample_valid = 1'b1;
      gyro_rate    = 16'sd1600;
      @(posedge clk); #1;
      sample_valid = 1'b0;
      first_ev = -1;
      for (int c = 2; c <= WD + 20 && first_ev < 0; c++) begin
        @(posedge clk); #1;
        if (est_valid) begin
          first_ev = c;
          check("wd_err_set", int'(wd_err), 1);
          check("wd_pred", int'(angle_est), exp_pred);
        end
      end
      check("wd_cycle", first_ev, WD + 2);
      m_est = exp_pred;
      @(posedge clk); #1;
      check("wd_sticky", int'(wd_err), 1);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
